// File: rtl/r2_tank_scheduler.sv
// r2 long-tank access scheduler: arbitrates two requesters and times the decoder strobes
// to the minor cycle in which the addressed word passes the heads. Optional: R2_SCHED_ROUND_ROBIN_EN.
module r2_tank_scheduler #(
  parameter int WORDS = 16,
  parameter int AW    = 7
) (
  input  logic                     clk,
  input  logic                     cls_pos,
  input  logic                     mc_strobe,
  input  logic                     req0_valid,
  input  logic                     req0_we,
  input  logic [AW-1:0]            req0_addr,
  output logic                     req0_ack,
  output logic                     req0_done,
  input  logic                     req1_valid,
  input  logic                     req1_we,
  input  logic [AW-1:0]            req1_addr,
  output logic                     req1_ack,
  output logic                     req1_done,
  output logic                     r2_read,
  output logic                     r2_write,
  output logic [7:0]               tank_sel,
  output logic [$clog2(WORDS)-1:0] word_pos,
  output logic                     busy
);

  localparam int WPW = $clog2(WORDS);
  localparam logic [WPW-1:0] WP_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   lat_addr;
  logic            lat_we;
  logic            gnt_id;
  logic            take, pick;
  logic            ack0_nxt, ack1_nxt, done0_nxt, done1_nxt;
  logic            rd_nxt, wr_nxt;
  logic [7:0]      sel_nxt, sel_dec;
  logic [WPW-1:0]  word_nxt, lat_word;
  logic [2:0]      lat_tank;

  assign word_nxt = word_pos + WP_ONE;
  assign lat_word = lat_addr[WPW-1:0];
  assign lat_tank = lat_addr[AW-1 -: 3];
  assign sel_dec  = 8'd1 << lat_tank;
  assign busy     = (state != IDLE);

`ifdef R2_SCHED_ROUND_ROBIN_EN
  logic last_gnt;

  // On a tie the requester not granted last time wins.
  assign pick = req1_valid && (!req0_valid || !last_gnt);

  always_ff @(posedge clk) begin
    if (cls_pos)   last_gnt <= 1'b1;
    else if (take) last_gnt <= pick;
  end
`else
  assign pick = !req0_valid;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    rd_nxt    = r2_read;
    wr_nxt    = r2_write;
    sel_nxt   = tank_sel;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          take      = 1'b1;
          ack0_nxt  = !pick;
          ack1_nxt  = pick;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // The heads see the word that the counter is about to reach.
        if (mc_strobe && word_nxt == lat_word) begin
          state_nxt = XFER;
          rd_nxt    = !lat_we;
          wr_nxt    = lat_we;
          sel_nxt   = sel_dec;
        end
      end
      XFER: begin
        if (mc_strobe) begin
          state_nxt = DONE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          sel_nxt   = 8'd0;
        end
      end
      DONE: begin
        done0_nxt = !gnt_id;
        done1_nxt = gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cls_pos) begin
      state     <= IDLE;
      word_pos  <= '0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      r2_read   <= 1'b0;
      r2_write  <= 1'b0;
      tank_sel  <= 8'd0;
    end else begin
      state     <= state_nxt;
      if (mc_strobe) word_pos <= word_nxt;
      req0_ack  <= ack0_nxt;
      req1_ack  <= ack1_nxt;
      req0_done <= done0_nxt;
      req1_done <= done1_nxt;
      r2_read   <= rd_nxt;
      r2_write  <= wr_nxt;
      tank_sel  <= sel_nxt;
    end
  end

  // Request capture: contents are only meaningful after a grant.
  always_ff @(posedge clk) begin
    if (take) begin
      lat_addr <= pick ? req1_addr : req0_addr;
      lat_we   <= pick ? req1_we : req0_we;
      gnt_id   <= pick;
    end
  end

endmodule
